// File: rtl/status_pkg.sv
// Shared register map and CTRL bit positions for the status register file
// and its per-channel ADC slices.
package status_pkg;

  localparam logic [7:0] ADDR_ID      = 8'h00;
  localparam logic [7:0] ADDR_VERSION = 8'h01;
  localparam logic [7:0] ADDR_CTRL    = 8'h02;
  localparam logic [7:0] ADDR_NEW     = 8'h03;
  localparam logic [7:0] ADDR_OVR     = 8'h04;
  localparam logic [7:0] SCRATCH_BASE = 8'h08;
  localparam logic [7:0] CH_BASE      = 8'h10;
  localparam int         CH_STRIDE    = 4;

  localparam int CTRL_CAP_EN  = 0;
  localparam int CTRL_CLR_MAX = 1;

  // Register offsets inside one channel window.
  typedef enum logic [1:0] {
    CH_SAMPLE_L = 2'd0,
    CH_SAMPLE_H = 2'd1,
    CH_MAX_L    = 2'd2,
    CH_MAX_H    = 2'd3
  } ch_reg_e;

endpackage

// File: rtl/status_adc_chan.sv
// One ADC channel: live sample, read snapshot, running maximum with its own
// snapshot, and the sticky NEW/OVR flags.
module status_adc_chan #(
  parameter int ADC_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_cap,
  input  logic [ADC_W-1:0] i_value,
  input  logic             i_snap_sample,
  input  logic             i_snap_max,
  input  logic             i_clr_max,
  input  logic             i_ovr_clr,
  output logic [15:0]      o_sample,
  output logic [15:0]      o_snap,
  output logic [15:0]      o_max,
  output logic [15:0]      o_max_snap,
  output logic             o_new,
  output logic             o_ovr
);

  logic [ADC_W-1:0] r_sample;
  logic [ADC_W-1:0] r_snap;
  logic [ADC_W-1:0] r_max;
  logic [ADC_W-1:0] r_max_snap;
  logic             r_new;
  logic             r_ovr;
  logic [ADC_W-1:0] w_max_base;
  logic [ADC_W-1:0] w_max_next;

  // A clear on the same edge as a capture leaves the new value as the maximum.
  always_comb begin
    w_max_base = i_clr_max ? '0 : r_max;
    w_max_next = w_max_base;
    if (i_cap && (i_value > w_max_base)) w_max_next = i_value;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sample   <= '0;
      r_snap     <= '0;
      r_max      <= '0;
      r_max_snap <= '0;
      r_new      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (i_snap_sample) r_snap <= r_sample;
      if (i_snap_max) r_max_snap <= r_max;
      if (i_cap) r_sample <= i_value;
      r_max <= w_max_next;
      if (i_cap) r_new <= 1'b1;
      else if (i_snap_sample) r_new <= 1'b0;
      if (i_cap && r_new) r_ovr <= 1'b1;
      else if (i_ovr_clr) r_ovr <= 1'b0;
    end
  end

  assign o_sample   = 16'(r_sample);
  assign o_snap     = 16'(r_snap);
  assign o_max      = 16'(r_max);
  assign o_max_snap = 16'(r_max_snap);
  assign o_new      = r_new;
  assign o_ovr      = r_ovr;

endmodule

// File: rtl/status_regfile.sv
// Byte-addressed status/control register file on the serial command path:
// address decode, CTRL/scratch storage and the one-byte response mux.
module status_regfile
  import status_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         ADC_W       = 16,
  parameter int         NUM_SCRATCH = 4,
  parameter logic [7:0] ID_VALUE    = 8'h55,
  parameter logic [7:0] VERSION     = 8'h02
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              address,
  input  logic                    address_valid,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic [NUM_CH*ADC_W-1:0] adc_data_value,
  input  logic [NUM_CH-1:0]       adc_data_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid
);

  localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  // Strobe semantics: address_valid marks a one-cycle access (rx_valid=1 write,
  // 0 read); every strobe yields exactly one tx_valid pulse on the next cycle,
  // carrying the register value as it was before that edge.
  logic             r_cap_en;
  logic [7:0]       r_scratch [SCR_N];
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;

  logic             w_wr;
  logic             w_rd;
  logic [2:0]       w_scr_idx;
  logic             w_scr_hit;
  logic [5:0]       w_ch_idx;
  ch_reg_e          w_ch_off;
  logic             w_ch_hit;
  logic             w_clr_max;
  logic [7:0]       w_rdata;
  logic [NUM_CH-1:0] w_new;
  logic [NUM_CH-1:0] w_ovr;
  logic [15:0]      w_sample   [NUM_CH];
  logic [15:0]      w_snap     [NUM_CH];
  logic [15:0]      w_max      [NUM_CH];
  logic [15:0]      w_max_snap [NUM_CH];

  assign w_wr      = address_valid & rx_valid;
  assign w_rd      = address_valid & ~rx_valid;
  assign w_scr_idx = address[2:0];
  assign w_scr_hit = (address[7:3] == SCRATCH_BASE[7:3]) &&
                     ({1'b0, w_scr_idx} < 4'(NUM_SCRATCH));
  // Channel windows are CH_STRIDE (4) bytes, so the index is the word address.
  assign w_ch_idx  = address[7:2] - CH_BASE[7:2];
  assign w_ch_off  = ch_reg_e'(address[1:0]);
  assign w_ch_hit  = (address >= CH_BASE) && (w_ch_idx < 6'(NUM_CH));
  assign w_clr_max = w_wr && (address == ADDR_CTRL) && rx_data[CTRL_CLR_MAX];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_sel;
    assign w_sel = w_ch_hit && (w_ch_idx == 6'(c));

    status_adc_chan #(.ADC_W(ADC_W)) u_chan (
      .clk           (clk),
      .rstn          (rstn),
      .i_cap         (adc_data_valid[c] & r_cap_en),
      .i_value       (adc_data_value[c*ADC_W +: ADC_W]),
      .i_snap_sample (w_rd && w_sel && (w_ch_off == CH_SAMPLE_L)),
      .i_snap_max    (w_rd && w_sel && (w_ch_off == CH_MAX_L)),
      .i_clr_max     (w_clr_max),
      .i_ovr_clr     (w_wr && (address == ADDR_OVR) && rx_data[c]),
      .o_sample      (w_sample[c]),
      .o_snap        (w_snap[c]),
      .o_max         (w_max[c]),
      .o_max_snap    (w_max_snap[c]),
      .o_new         (w_new[c]),
      .o_ovr         (w_ovr[c])
    );
  end

  always_comb begin
    w_rdata = 8'h00;
    case (address)
      ADDR_ID:      w_rdata = ID_VALUE;
      ADDR_VERSION: w_rdata = VERSION;
      ADDR_CTRL:    w_rdata = {7'b0, r_cap_en};
      ADDR_NEW:     w_rdata = 8'(w_new);
      ADDR_OVR:     w_rdata = 8'(w_ovr);
      default:      w_rdata = 8'h00;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (w_scr_hit && (w_scr_idx == 3'(i))) w_rdata = r_scratch[i];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_hit && (w_ch_idx == 6'(c))) begin
        case (w_ch_off)
          CH_SAMPLE_L: w_rdata = w_sample[c][7:0];
          CH_SAMPLE_H: w_rdata = w_snap[c][15:8];
          CH_MAX_L:    w_rdata = w_max[c][7:0];
          CH_MAX_H:    w_rdata = w_max_snap[c][15:8];
          default:     w_rdata = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_cap_en   <= 1'b1;
      for (int i = 0; i < SCR_N; i++) r_scratch[i] <= 8'h00;
    end else begin
      r_tx_valid <= address_valid;
      r_tx_data  <= address_valid ? w_rdata : 8'h00;
      if (w_wr && (address == ADDR_CTRL)) r_cap_en <= rx_data[CTRL_CAP_EN];
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (w_wr && w_scr_hit && (w_scr_idx == 3'(i))) r_scratch[i] <= rx_data;
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_status_regfile.sv
// Bench for status_regfile: directed register-map scenarios plus random traffic,
// every cycle compared against a behavioural register-map model.
module tb_status_regfile;

  localparam int NUM_CH      = 4;
  localparam int ADC_W       = 16;
  localparam int NUM_SCRATCH = 4;
  localparam int VW          = NUM_CH * ADC_W;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        address = 8'h00;
  logic              address_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [VW-1:0]     adc_data_value = '0;
  logic [NUM_CH-1:0] adc_data_valid = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;

  int n_pass = 0;
  int n_total = 0;

  status_regfile #(
    .NUM_CH(NUM_CH), .ADC_W(ADC_W), .NUM_SCRATCH(NUM_SCRATCH),
    .ID_VALUE(8'h55), .VERSION(8'h02)
  ) dut (
    .clk(clk), .rstn(rstn), .address(address), .address_valid(address_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .adc_data_value(adc_data_value),
    .adc_data_valid(adc_data_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int   m_sample [NUM_CH];
  int   m_snap   [NUM_CH];
  int   m_max    [NUM_CH];
  int   m_msnap  [NUM_CH];
  bit   m_new    [NUM_CH];
  bit   m_ovr    [NUM_CH];
  int   m_scr    [NUM_SCRATCH];
  bit   m_cap_en;
  logic       exp_v;
  logic [7:0] exp_d;
  bit   cmp_en = 1'b0;

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sample[c] = 0; m_snap[c] = 0; m_max[c] = 0; m_msnap[c] = 0;
      m_new[c] = 1'b0; m_ovr[c] = 1'b0;
    end
    for (int i = 0; i < NUM_SCRATCH; i++) m_scr[i] = 0;
    m_cap_en = 1'b1;
    exp_v = 1'b0;
    exp_d = 8'h00;
  endtask

  function automatic logic [7:0] m_read(input int a);
    logic [7:0] r;
    int c;
    int k;
    r = 8'h00;
    if (a == 0) r = 8'h55;
    else if (a == 1) r = 8'h02;
    else if (a == 2) r = m_cap_en ? 8'h01 : 8'h00;
    else if (a == 3) begin
      for (int i = 0; i < NUM_CH; i++) if (m_new[i]) r = r + 8'(1 << i);
    end else if (a == 4) begin
      for (int i = 0; i < NUM_CH; i++) if (m_ovr[i]) r = r + 8'(1 << i);
    end else if (a >= 8 && a < 8 + NUM_SCRATCH) r = 8'(m_scr[a-8]);
    else if (a >= 16 && a < 16 + 4 * NUM_CH) begin
      c = (a - 16) / 4;
      k = (a - 16) % 4;
      case (k)
        0: r = 8'(m_sample[c] % 256);
        1: r = 8'(m_snap[c] / 256);
        2: r = 8'(m_max[c] % 256);
        default: r = 8'(m_msnap[c] / 256);
      endcase
    end
    return r;
  endfunction

  task automatic m_step();
    bit   cap [NUM_CH];
    bit   was_new [NUM_CH];
    int   a;
    int   c;
    int   val;
    logic [7:0] d;
    a = int'(address);
    d = rx_data;
    for (int i = 0; i < NUM_CH; i++) begin
      was_new[i] = m_new[i];
      cap[i] = adc_data_valid[i] && m_cap_en;
    end
    exp_v = address_valid;
    exp_d = address_valid ? m_read(a) : 8'h00;
    if (address_valid && !rx_valid && a >= 16 && a < 16 + 4 * NUM_CH) begin
      c = (a - 16) / 4;
      if ((a - 16) % 4 == 0) begin
        m_snap[c] = m_sample[c];
        m_new[c] = 1'b0;
      end else if ((a - 16) % 4 == 2) m_msnap[c] = m_max[c];
    end
    if (address_valid && rx_valid) begin
      if (a == 2) begin
        m_cap_en = d[0];
        if (d[1]) for (int i = 0; i < NUM_CH; i++) m_max[i] = 0;
      end
      if (a == 4) for (int i = 0; i < NUM_CH; i++) if (d[i]) m_ovr[i] = 1'b0;
      if (a >= 8 && a < 8 + NUM_SCRATCH) m_scr[a-8] = int'(d);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (cap[i]) begin
        val = int'(adc_data_value[i*ADC_W +: ADC_W]);
        if (was_new[i]) m_ovr[i] = 1'b1;
        m_sample[i] = val;
        m_new[i] = 1'b1;
        if (val > m_max[i]) m_max[i] = val;
      end
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_reset();
    else m_step();
  end

  // Every-cycle comparison of the response port against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_total++;
      if (tx_valid === exp_v && tx_data === exp_d) n_pass++;
      else $display("FAIL cycle_cmp t=%0t tx_valid=%b tx_data=%h expected valid=%b data=%h",
                    $time, tx_valid, tx_data, exp_v, exp_d);
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] rsp;
  logic       rsp_v;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h expected=%h", name, got, want);
  endtask

  task automatic drive(input logic av, input logic [7:0] a, input logic wr,
                       input logic [7:0] d, input logic [NUM_CH-1:0] vm,
                       input logic [VW-1:0] vals);
    address_valid = av; address = a; rx_valid = wr; rx_data = d;
    adc_data_valid = vm; adc_data_value = vals;
    @(posedge clk);
    #1;
    rsp = tx_data;
    rsp_v = tx_valid;
    address_valid = 1'b0; rx_valid = 1'b0; adc_data_valid = '0;
  endtask

  task automatic rdchk(input string name, input logic [7:0] a, input logic [7:0] want);
    drive(1'b1, a, 1'b0, 8'h00, '0, '0);
    chk(name, rsp, want);
  endtask

  task automatic wrchk(input string name, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] want);
    drive(1'b1, a, 1'b1, d, '0, '0);
    chk(name, rsp, want);
  endtask

  task automatic cap(input logic [NUM_CH-1:0] vm, input logic [15:0] v);
    drive(1'b0, 8'h00, 1'b0, 8'h00, vm, {NUM_CH{v}});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("reset_tx_data", tx_data, 8'h00);
    rstn = 1'b1;

    // ID / version / CTRL defaults, unmapped window
    rdchk("id", 8'h00, 8'h55);
    chk("id_latency_valid", {7'b0, rsp_v}, 8'h01);
    rdchk("version", 8'h01, 8'h02);
    rdchk("ctrl_reset", 8'h02, 8'h01);
    rdchk("unmapped_ch4", 8'h20, 8'h00);

    // scratch and read-only write
    wrchk("scratch_wr_old", 8'h08, 8'hA5, 8'h00);
    rdchk("scratch_rd", 8'h08, 8'hA5);
    wrchk("id_wr_resp", 8'h00, 8'hFF, 8'h55);
    rdchk("id_after_wr", 8'h00, 8'h55);

    // coherent sample read
    cap(4'b0010, 16'h1234);
    rdchk("new_after_cap", 8'h03, 8'h02);
    rdchk("ch1_sample_l", 8'h14, 8'h34);
    rdchk("new_cleared", 8'h03, 8'h00);
    cap(4'b0010, 16'hBEEF);
    rdchk("ch1_sample_h_snap", 8'h15, 8'h12);

    // overrun and W1C
    cap(4'b0001, 16'h0001);
    cap(4'b0001, 16'h0002);
    rdchk("ovr_set", 8'h04, 8'h01);
    wrchk("ovr_w1c_resp", 8'h04, 8'h01, 8'h01);
    rdchk("ovr_cleared", 8'h04, 8'h00);
    drive(1'b1, 8'h04, 1'b1, 8'h01, 4'b0001, {NUM_CH{16'h0003}});
    chk("ovr_w1c_vs_set_resp", rsp, 8'h00);
    rdchk("ovr_set_wins", 8'h04, 8'h01);

    // running maximum, clr_max
    cap(4'b0100, 16'h0100);
    cap(4'b0100, 16'h0300);
    cap(4'b0100, 16'h0200);
    rdchk("ch2_max_l", 8'h1A, 8'h00);
    rdchk("ch2_max_h", 8'h1B, 8'h03);
    wrchk("ctrl_clr_resp", 8'h02, 8'h03, 8'h01);
    rdchk("max_l_cleared", 8'h1A, 8'h00);
    rdchk("max_h_cleared", 8'h1B, 8'h00);
    rdchk("ctrl_clr_reads0", 8'h02, 8'h01);
    drive(1'b1, 8'h02, 1'b1, 8'h03, 4'b0100, {NUM_CH{16'h0050}});
    rdchk("max_clr_load_l", 8'h1A, 8'h50);
    rdchk("max_clr_load_h", 8'h1B, 8'h00);

    // capture disabled
    wrchk("ctrl_off_resp", 8'h02, 8'h00, 8'h01);
    cap(4'b1111, 16'hFFFF);
    rdchk("new_unchanged", 8'h03, 8'h07);
    rdchk("ovr_unchanged", 8'h04, 8'h05);
    rdchk("ch0_sample_unchanged", 8'h10, 8'h03);
    rdchk("ch2_max_unchanged", 8'h1A, 8'h50);
    wrchk("ctrl_on_resp", 8'h02, 8'h01, 8'h00);

    // reset while a response is pending
    address_valid = 1'b1; address = 8'h00; rx_valid = 1'b0;
    #3;
    rstn = 1'b0;
    address_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_drop_tx_valid", {7'b0, tx_valid}, 8'h00);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rdchk("post_reset_ctrl", 8'h02, 8'h01);
    rdchk("post_reset_scratch", 8'h08, 8'h00);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      logic [NUM_CH-1:0] vm;
      if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(0, 255));
      else a = 8'($urandom_range(0, 8 + 16 + 4 * NUM_CH - 1) - 8 + 8);
      vm = NUM_CH'($urandom) & NUM_CH'($urandom);
      drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) == 0,
            8'($urandom), vm, {$urandom, $urandom});
    end
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
